// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: loader state encoding and default program base address.
// CHK exists only when PROG_LOADER_CHECKSUM_EN is defined.
package prog_loader_pkg;
  localparam logic [31:0] DEF_BASE_ADDR = 32'h8002_0000;
`ifdef PROG_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LOAD, CHK, SETTLE, RUN, ERR} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, RUN, ERR} state_t;
`endif
endpackage

// File: rtl/prog_loader.sv
// prog_loader: streams program words into memory, then holds the PC in reset before releasing it.
// Define PROG_LOADER_CHECKSUM_EN to add a trailing checksum beat that is verified before running.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int MAX_WORDS = 1024,
  parameter int SETTLE_CYC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        s_valid,
  input  logic [31:0] s_data,
  input  logic        s_last,
  output logic        s_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  output logic        mem_we,
  output logic        mem_enable,
  output logic        pc_rst,
  output logic        load_done,
  output logic        load_err,
  output logic [10:0] word_count
);
  localparam logic [10:0] MAXW = 11'(MAX_WORDS);
  state_t state, state_nx;
  logic [15:0] cnt;
  logic beat, room, wr, clr;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [31:0] sum;
  assign s_ready = state == LOAD || state == CHK;
`else
  assign s_ready = state == LOAD;
`endif
  assign beat = s_valid & s_ready;
  assign room = word_count < MAXW;
  assign wr = beat && state == LOAD && room;
  assign clr = start && (state == IDLE || state == RUN || state == ERR);
  assign pc_rst = state != RUN;
  assign load_done = state == RUN;
  assign load_err = state == ERR;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, RUN, ERR: state_nx = start ? LOAD : state;
`ifdef PROG_LOADER_CHECKSUM_EN
      LOAD: state_nx = !beat ? LOAD : !room ? ERR : s_last ? CHK : LOAD;
      CHK: state_nx = !beat ? CHK : s_data == sum ? SETTLE : ERR;
`else
      LOAD: state_nx = !beat ? LOAD : !room ? ERR : s_last ? SETTLE : LOAD;
`endif
      SETTLE: state_nx = cnt == 16'(SETTLE_CYC - 1) ? RUN : SETTLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
      mem_enable <= 1'b0;
      word_count <= '0;
      cnt <= '0;
    end else begin
      mem_enable <= 1'b1;
      mem_we <= wr;
      if (wr) begin
        mem_addr <= BASE_ADDR + {19'd0, word_count, 2'b00};
        mem_data <= s_data;
      end
      word_count <= clr ? '0 : wr ? word_count + 11'd1 : word_count;
      cnt <= state == SETTLE ? cnt + 16'd1 : '0;
    end
`ifdef PROG_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) sum <= '0;
    else sum <= clr ? '0 : wr ? sum + s_data : sum;
`endif
endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'h8002_0000: byte address of first program word.
REQ-002 Parameter MAX_WORDS, default 1024: program capacity in words.
REQ-003 Parameter SETTLE_CYC, default 4: cycles pc_rst stays high after the final write.
REQ-004 Port list: clk in 1 system clock; rst in 1 reset; one clock; reset is asynchronous and active-low.
REQ-005 Port list: start in 1 begin/restart load; s_valid in 1 word present; s_data in 32 program word; s_last in 1 final program word; s_ready out 1 loader accepts word.
REQ-006 Port list: mem_addr out 32 write address; mem_data out 32 write data; mem_we out 1 write strobe, feeds memory read_not_write as ~mem_we; mem_enable out 1 memory enable.
REQ-007 Port list: pc_rst out 1 holds PC at start address; load_done out 1 program running; load_err out 1 load failed; word_count out 11 words written.

Function
REQ-008 The FSM SHALL have states IDLE, LOAD, CHK (macro builds only), SETTLE, RUN and ERR.
REQ-009 In IDLE, start=1 SHALL move the FSM to LOAD and clear word_count.
REQ-010 The FSM SHALL hold s_ready=1 only in LOAD (and CHK), combinationally from state.
REQ-011 Each beat (s_valid&s_ready) in LOAD with word_count<MAX_WORDS SHALL register mem_addr=BASE_ADDR+4*word_count, mem_data=s_data and mem_we=1 for exactly the next cycle, then increment word_count; write latency is one cycle.
REQ-012 mem_we SHALL be 0 in every cycle without a preceding accepted beat; back-to-back beats SHALL give back-to-back writes at consecutive addresses.
REQ-013 A beat with s_last=1 SHALL be written and then move the FSM to SETTLE (CHK when macro defined).
REQ-014 A beat arriving when word_count==MAX_WORDS SHALL NOT be written and SHALL move the FSM to ERR.
REQ-015 SETTLE SHALL count SETTLE_CYC cycles, then enter RUN.
REQ-016 pc_rst SHALL be 1 in all states except RUN; load_done SHALL be 1 only in RUN; load_err SHALL be 1 only in ERR.
REQ-017 start in RUN or ERR SHALL re-enter LOAD, clear word_count and reassert pc_rst next cycle; start in LOAD/CHK/SETTLE SHALL be ignored.
REQ-018 mem_enable SHALL be 1 at all times out of reset.
REQ-019 word_count SHALL saturate at MAX_WORDS, never wrap.

Reset
REQ-020 rst=0 SHALL asynchronously force IDLE, s_ready=0, mem_we=0, mem_addr=0, mem_data=0, word_count=0, pc_rst=1, load_done=0, load_err=0, mem_enable=0.
REQ-021 Reset mid-LOAD SHALL abort without a trailing write; release SHALL resume in IDLE.

Configuration
REQ-022 With PROG_LOADER_CHECKSUM_EN defined, the loader SHALL accumulate a 32-bit wrapping sum of written words and, in CHK, accept one further beat as expected sum (not written): match -> SETTLE, mismatch -> ERR.
REQ-023 Without PROG_LOADER_CHECKSUM_EN, CHK and the accumulator SHALL not exist and s_last SHALL go directly to SETTLE.

Structure
REQ-024 The state enum and default BASE_ADDR SHALL live in the shared proc package.
REQ-025 The design SHALL be a single module; no sub-module.

Verification
REQ-026 start, 3 beats 0x11,0x22,0x33 (last on 3rd) -> writes at 0x80020000/04/08, word_count=3, pc_rst falls 4 cycles after last write, load_done=1.
REQ-027 s_valid gapped every other cycle -> mem_we pulses only after accepted beats, addresses contiguous.
REQ-028 MAX_WORDS=4, 5 beats no s_last -> 4 writes, 5th dropped, load_err=1, pc_rst=1.
REQ-029 rst low after 2nd beat -> mem_we=0 immediately, IDLE, pc_rst=1; fresh start reloads from 0x80020000.
REQ-030 Macro on: words 1,2 then 3 -> RUN; then 4 -> ERR.
REQ-031 start in RUN -> pc_rst=1 next cycle, word_count=0, new load succeeds.
